timer_dev: RTL and testbench

- Memory-mapped countdown timer. It is device 0 behind the system bridge, in the 0x0000_7F00–0x0000_7F0B window.
- Consumes the bridge's device-side bus: word offset, write data, byte enables, write enable.
- Returns read data to the bridge's DEV0 read input.
- Drives interrupt request line IRQ0, which the bridge folds into HWInt[2].

---
 rtl/timer_dev_pkg.sv | 29 ++
 rtl/timer_be_merge.sv | 29 ++
 rtl/timer_dev.sv | 119 +++++++++++
 tb/tb_timer_dev.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_dev_pkg.sv
// rtl/timer_dev_pkg.sv - shared register map, CTRL layout and FSM encoding for timer_dev
package timer_dev_pkg;

  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_PRESET = 2'd1;
  localparam logic [1:0] OFF_COUNT  = 2'd2;
  localparam logic [1:0] OFF_RSVD   = 2'd3;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_AUTO    = 2'b01;

  localparam int CTRL_EN       = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_IM       = 3;
  localparam int CTRL_W        = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_t;

  // Only 01 reloads; 00, 10 and 11 all behave as one-shot.
  function automatic logic is_auto(input logic [1:0] mode);
    return (mode == MODE_AUTO);
  endfunction

endpackage

// File: rtl/timer_be_merge.sv
// rtl/timer_be_merge.sv - byte-enable merge of a register write; pass-through unless TIMER_BYTE_WRITE_EN
module timer_be_merge #(
  parameter int W = 32
) (
  input  logic [W-1:0] old_word,
  input  logic [W-1:0] wdata,
  input  logic [3:0]   be,
  output logic [W-1:0] merged
);

`ifdef TIMER_BYTE_WRITE_EN
  always_comb begin
    merged = old_word;
    for (int i = 0; i < W; i++) begin
      if (be[i >> 3]) merged[i] = wdata[i];
    end
  end

  // Narrow registers (CTRL) only look at be[0].
  logic unused_be;
  assign unused_be = ^be;
`else
  assign merged = wdata;

  logic unused_inputs;
  assign unused_inputs = ^{old_word, be};
`endif

endmodule

// File: rtl/timer_dev.sv
// rtl/timer_dev.sv - memory-mapped countdown timer (bridge device 0, IRQ0); TIMER_BYTE_WRITE_EN enables byte writes
module timer_dev
  import timer_dev_pkg::*;
#(
  parameter int          CNT_W        = 32,
  parameter logic [31:0] RESET_PRESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  be,
  input  logic        we,
  output logic [31:0] rdata,
  output logic        irq
);

  logic [CTRL_W-1:0] ctrl;
  logic [CNT_W-1:0]  preset;
  logic [CNT_W-1:0]  count;
  state_t            state;
  logic              irq_flag;

  logic              ctrl_wr;
  logic              preset_wr;
  logic [CTRL_W-1:0] ctrl_new;
  logic [CNT_W-1:0]  preset_new;
  logic              en_eff;
  logic              auto_mode;
  logic              im_rise;

  assign ctrl_wr   = we && (addr == OFF_CTRL);
  assign preset_wr = we && (addr == OFF_PRESET);
  assign auto_mode = is_auto(ctrl[CTRL_MODE_LSB +: 2]);

  timer_be_merge #(.W(CTRL_W)) u_ctrl_merge (
    .old_word (ctrl),
    .wdata    (wdata[CTRL_W-1:0]),
    .be       (be),
    .merged   (ctrl_new)
  );

  timer_be_merge #(.W(CNT_W)) u_preset_merge (
    .old_word (preset),
    .wdata    (wdata[CNT_W-1:0]),
    .be       (be),
    .merged   (preset_new)
  );

  // IDLE reacts to the EN value being written this cycle so LOAD follows the write edge directly.
  assign en_eff  = ctrl_wr ? ctrl_new[CTRL_EN] : ctrl[CTRL_EN];
  // Unmasking a pending one-shot interrupt must not discard it.
  assign im_rise = ctrl_wr && ctrl_new[CTRL_IM] && !ctrl[CTRL_IM];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl     <= '0;
      preset   <= RESET_PRESET[CNT_W-1:0];
      count    <= '0;
      state    <= ST_IDLE;
      irq_flag <= 1'b0;
    end else begin
      if (preset_wr) preset <= preset_new;

      if (ctrl_wr) begin
        ctrl <= ctrl_new;
      end else if (state == ST_INT && !auto_mode) begin
        ctrl[CTRL_EN] <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (en_eff) state <= ST_LOAD;
        end
        ST_LOAD: begin
          count <= preset;
          state <= ST_CNT;
        end
        ST_CNT: begin
          if (!ctrl[CTRL_EN]) begin
            state <= ST_IDLE;
          end else if (count == '0) begin
            state <= ST_INT;
          end else begin
            count <= count - 1'b1;
          end
        end
        ST_INT: begin
          state <= auto_mode ? ST_LOAD : ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase

      if (auto_mode) begin
        irq_flag <= (state == ST_INT);
      end else if (state == ST_INT) begin
        irq_flag <= 1'b1;
      end else if (preset_wr || (ctrl_wr && !im_rise)) begin
        irq_flag <= 1'b0;
      end
    end
  end

  assign irq = ctrl[CTRL_IM] & irq_flag;

  always_comb begin
    rdata = '0;
    case (addr)
      OFF_CTRL:   rdata[CTRL_W-1:0] = ctrl;
      OFF_PRESET: rdata[CNT_W-1:0]  = preset;
      OFF_COUNT:  rdata[CNT_W-1:0]  = count;
      OFF_RSVD:   rdata = '0;
    endcase
  end

  logic unused_wdata;
  assign unused_wdata = ^wdata;

endmodule

// File: tb/tb_timer_dev.sv
// tb/tb_timer_dev.sv - self-checking bench for timer_dev against a behavioural model
`timescale 1ns/1ps
module tb_timer_dev;

  localparam logic [31:0] RP = 32'h0000_00A5;
`ifdef TIMER_BYTE_WRITE_EN
  localparam logic [31:0] EXP_BYTE = 32'h11BB_33DD;
`else
  localparam logic [31:0] EXP_BYTE = 32'hAABB_CCDD;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        we;
  logic [31:0] rdata;
  logic        irq;

  int checks = 0;
  int errors = 0;

  int exp_cnt [10] = '{2, 1, 0, 0, 0, 2, 1, 0, 0, 0};
  int exp_irq [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

  timer_dev #(.CNT_W(32), .RESET_PRESET(RP)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .addr    (addr),
    .wdata   (wdata),
    .be      (be),
    .we      (we),
    .rdata   (rdata),
    .irq     (irq)
  );

  always #10 clk = ~clk;

  // Reference: phase 0 idle, 1 loading, 2 counting, 3 expired.
  logic [3:0]  m_ctrl;
  logic [31:0] m_preset;
  logic [31:0] m_count;
  int          m_ph;
  logic        m_flag;

  function automatic logic [31:0] word_merge(input logic [31:0] o, input logic [31:0] w, input logic [3:0] b);
    logic [31:0] r;
    r = w;
`ifdef TIMER_BYTE_WRITE_EN
    r = o;
    for (int k = 0; k < 4; k++) if (b[k]) r[8*k +: 8] = w[8*k +: 8];
`endif
    return r;
  endfunction

  function automatic logic [3:0] ctrl_merge(input logic [3:0] o, input logic [3:0] w, input logic [3:0] b);
    logic [3:0] r;
    r = w;
`ifdef TIMER_BYTE_WRITE_EN
    r = b[0] ? w : o;
`endif
    return r;
  endfunction

  function automatic logic [31:0] model_rd(input logic [1:0] a);
    case (a)
      2'd0:    return {28'b0, m_ctrl};
      2'd1:    return m_preset;
      2'd2:    return m_count;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_ctrl = 4'h0; m_preset = RP; m_count = 32'h0; m_ph = 0; m_flag = 1'b0;
  endtask

  task automatic model_step();
    logic [3:0]  c_n;
    logic [31:0] p_n, cnt_n;
    int          ph_n;
    logic        f_n;
    bit          cw, pw, reload;
    cw = (we === 1'b1) && (addr == 2'd0);
    pw = (we === 1'b1) && (addr == 2'd1);
    c_n = cw ? ctrl_merge(m_ctrl, wdata[3:0], be) : m_ctrl;
    p_n = pw ? word_merge(m_preset, wdata, be) : m_preset;
    cnt_n = m_count;
    ph_n = m_ph;
    reload = (m_ctrl[2:1] == 2'b01);
    if (m_ph == 0) begin
      if (c_n[0]) ph_n = 1;
    end else if (m_ph == 1) begin
      cnt_n = m_preset;
      ph_n = 2;
    end else if (m_ph == 2) begin
      if (!m_ctrl[0]) ph_n = 0;
      else if (m_count == 0) ph_n = 3;
      else cnt_n = m_count - 1;
    end else begin
      ph_n = reload ? 1 : 0;
      if (!reload && !cw) c_n[0] = 1'b0;
    end
    if (reload) f_n = (m_ph == 3);
    else if (m_ph == 3) f_n = 1'b1;
    else if (pw || (cw && !(c_n[3] && !m_ctrl[3]))) f_n = 1'b0;
    else f_n = m_flag;
    m_ctrl = c_n; m_preset = p_n; m_count = cnt_n; m_ph = ph_n; m_flag = f_n;
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) model_reset();
    else model_step();
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("model_irq", {31'b0, irq}, {31'b0, m_ctrl[3] & m_flag});
    chk("model_rdata", rdata, model_rd(addr));
  end

  task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic [3:0] b);
    addr = a; wdata = d; be = b; we = 1'b1;
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rd_chk(input string name, input logic [1:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    chk(name, rdata, exp);
  endtask

  task automatic irq_chk(input string name, input logic exp);
    #1;
    chk(name, {31'b0, irq}, {31'b0, exp});
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; we = 1'b0; addr = 2'd0; wdata = 32'h0; be = 4'h0;
    tick(2);
    rd_chk("rst_ctrl", 2'd0, 32'h0);
    rd_chk("rst_preset", 2'd1, RP);
    rd_chk("rst_count", 2'd2, 32'h0);
    irq_chk("rst_irq", 1'b0);
    reset_n = 1'b1;
    tick(1);

    // One-shot: PRESET=5 fires 8 edges after the CTRL write
    wr(2'd1, 32'd5, 4'hF);
    wr(2'd0, 32'h9, 4'hF);
    for (int k = 1; k <= 8; k++) begin
      tick(1);
      if (k >= 7) irq_chk((k == 8) ? "oneshot_irq_rise" : "oneshot_irq_early", k == 8);
    end
    rd_chk("oneshot_ctrl", 2'd0, 32'h8);
    tick(3);
    irq_chk("oneshot_irq_hold", 1'b1);
    wr(2'd0, 32'h8, 4'hF);
    irq_chk("oneshot_ctrl_clear", 1'b0);

    // Auto-reload: 1-cycle pulse every 5 cycles
    do_reset();
    wr(2'd1, 32'd2, 4'hF);
    wr(2'd0, 32'hB, 4'hF);
    for (int k = 0; k < 10; k++) begin
      tick(1);
      rd_chk("auto_count", 2'd2, exp_cnt[k]);
      irq_chk("auto_irq", exp_irq[k] != 0);
    end

    // Masked expiry keeps the flag pending until IM is set
    do_reset();
    wr(2'd1, 32'd1, 4'hF);
    wr(2'd0, 32'h1, 4'hF);
    tick(6);
    irq_chk("masked_irq", 1'b0);
    rd_chk("masked_ctrl", 2'd0, 32'h0);
    wr(2'd0, 32'h8, 4'hF);
    irq_chk("unmask_irq", 1'b1);

    // Collisions
    do_reset();
    wr(2'd1, 32'd6, 4'hF);
    wr(2'd0, 32'h9, 4'hF);
    tick(4);
    rd_chk("coll_cnt3", 2'd2, 32'd3);
    wr(2'd1, 32'd9, 4'hF);
    rd_chk("coll_cnt2", 2'd2, 32'd2);
    tick(1);
    rd_chk("coll_cnt1", 2'd2, 32'd1);
    tick(1);
    rd_chk("coll_cnt0", 2'd2, 32'd0);
    wr(2'd2, 32'hFFFF_FFFF, 4'hF);
    rd_chk("coll_count_ro", 2'd2, 32'd0);
    wr(2'd0, 32'h9, 4'hF);
    rd_chk("coll_int_ctrl", 2'd0, 32'h9);
    irq_chk("coll_int_irq", 1'b1);
    tick(2);
    rd_chk("coll_reload9", 2'd2, 32'd9);

    // Byte enables and reserved offset
    do_reset();
    wr(2'd1, 32'h1122_3344, 4'hF);
    wr(2'd1, 32'hAABB_CCDD, 4'b0101);
    rd_chk("byte_preset", 2'd1, EXP_BYTE);
    wr(2'd3, 32'hFFFF_FFFF, 4'hF);
    rd_chk("rsvd_read", 2'd3, 32'h0);

    // Asynchronous reset mid-count
    do_reset();
    wr(2'd1, 32'd20, 4'hF);
    wr(2'd0, 32'h9, 4'hF);
    tick(5);
    #3;
    reset_n = 1'b0;
    irq_chk("async_irq", 1'b0);
    rd_chk("async_count", 2'd2, 32'h0);
    rd_chk("async_preset", 2'd1, RP);
    rd_chk("async_ctrl", 2'd0, 32'h0);
    reset_n = 1'b1;
    tick(1);

    // Random traffic checked cycle by cycle against the model
    for (int i = 0; i < 800; i++) begin
      addr = 2'($urandom_range(0, 3));
      be = 4'($urandom);
      we = ($urandom_range(0, 5) == 0);
      wdata = (addr == 2'd1) ? 32'($urandom_range(0, 12)) : $urandom;
      tick(1);
    end
    we = 1'b0;
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
